// File: rtl/gpio_switch_debounce.sv
// Switch-bank conditioner: per-bit synchronizer and debounce counter producing a
// stable level, registered rise/fall/changed strobes and a wrapping event counter.
`timescale 1ns/1ps
module gpio_switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic             SYSTEMCLOCK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] gpio_switch,
  output logic [WIDTH-1:0] switch_stable,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
  output logic             switch_changed,
  output logic [7:0]       event_count
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  sync_s;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_r;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_nxt_s;
  logic [WIDTH-1:0]                  flip_s;
  logic [WIDTH-1:0]                  stable_r;
  logic [WIDTH-1:0]                  rise_r;
  logic [WIDTH-1:0]                  fall_r;
  logic                              changed_r;
  logic [7:0]                        event_count_r;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchronizer chain: stage 0 samples the raw asynchronous switch levels.
  always_ff @(posedge SYSTEMCLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= gpio_switch;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // Debounce decision: count consecutive mismatches, flip the bit on the last one.
  always_comb begin
    flip_s    = '0;
    cnt_nxt_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_s[i] == stable_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_LAST) begin
        flip_s[i]    = 1'b1;
        cnt_nxt_s[i] = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Per-bit debounce counters.
  always_ff @(posedge SYSTEMCLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Stable level and strobes share one edge so consumers see them coherently.
  always_ff @(posedge SYSTEMCLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      stable_r  <= '0;
      rise_r    <= '0;
      fall_r    <= '0;
      changed_r <= 1'b0;
    end else begin
      stable_r  <= stable_r ^ flip_s;
      rise_r    <= flip_s & ~stable_r;
      fall_r    <= flip_s & stable_r;
      changed_r <= |flip_s;
    end
  end

  // Event counter: one increment per changed cycle, however many bits flipped.
  always_ff @(posedge SYSTEMCLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      event_count_r <= 8'h00;
    end else if (|flip_s) begin
      event_count_r <= event_count_r + 8'h01;
    end else begin
      event_count_r <= event_count_r;
    end
  end

  assign switch_stable  = stable_r;
  assign switch_rise    = rise_r;
  assign switch_fall    = fall_r;
  assign switch_changed = changed_r;
  assign event_count    = event_count_r;

endmodule

// File: tb/tb_gpio_switch_debounce.sv
// Self-checking bench for gpio_switch_debounce: sliding-window reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_gpio_switch_debounce;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int HLEN = SYNC + DEB - 1;

  logic         SYSTEMCLOCK;
  logic         RESET_N;
  logic [W-1:0] gpio_switch;
  logic [W-1:0] switch_stable;
  logic [W-1:0] switch_rise;
  logic [W-1:0] switch_fall;
  logic         switch_changed;
  logic [7:0]   event_count;

  int checks = 0;
  int errors = 0;

  gpio_switch_debounce #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .SYSTEMCLOCK   (SYSTEMCLOCK),
    .RESET_N       (RESET_N),
    .gpio_switch   (gpio_switch),
    .switch_stable (switch_stable),
    .switch_rise   (switch_rise),
    .switch_fall   (switch_fall),
    .switch_changed(switch_changed),
    .event_count   (event_count)
  );

  initial SYSTEMCLOCK = 1'b0;
  always #4.98 SYSTEMCLOCK = ~SYSTEMCLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: hist[0] is the raw level sampled at the previous edge,
  // hist[n] the one n edges earlier. A bit flips when every synced sample of the
  // last DEB cycles disagreed with the stable level.
  logic [W-1:0] hist [HLEN];
  logic [W-1:0] m_stable, m_rise, m_fall;
  logic         m_changed;
  logic [7:0]   m_count;

  always @(posedge SYSTEMCLOCK) begin
    logic [W-1:0] flip;
    #1;
    if (!RESET_N) begin
      for (int i = 0; i < HLEN; i++) hist[i] = '0;
      m_stable = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0; m_count = 8'h00;
    end else begin
      flip = '1;
      for (int j = 1; j <= DEB; j++) flip = flip & (hist[j+SYNC-2] ^ m_stable);
      m_rise    = flip & ~m_stable;
      m_fall    = flip & m_stable;
      m_changed = |flip;
      m_count   = m_count + ((|flip) ? 8'h01 : 8'h00);
      m_stable  = m_stable ^ flip;
      for (int i = HLEN - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = gpio_switch;
    end
    check("model_stable",  32'(switch_stable),  32'(m_stable));
    check("model_rise",    32'(switch_rise),    32'(m_rise));
    check("model_fall",    32'(switch_fall),    32'(m_fall));
    check("model_changed", 32'(switch_changed), 32'(m_changed));
    check("model_count",   32'(event_count),    32'(m_count));
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge SYSTEMCLOCK);
  endtask

  // Counts edges from now until switch_stable[bit] equals lvl; 0 if never within 40.
  task automatic measure(input int bit_i, input logic lvl, output int edge_n, output int pulses);
    edge_n = 0;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge SYSTEMCLOCK);
      #1;
      if (switch_changed) pulses++;
      if (edge_n == 0 && switch_stable[bit_i] == lvl) edge_n = n;
    end
  endtask

  initial begin
    int e, p;
    RESET_N     = 1'b0;
    gpio_switch = 4'hF;

    // Reset values with switches high
    repeat (5) @(posedge SYSTEMCLOCK);
    #2;
    check("reset_stable", 32'(switch_stable), 32'h0);
    check("reset_count",  32'(event_count),   32'h0);
    @(negedge SYSTEMCLOCK);
    gpio_switch = 4'h0;
    RESET_N     = 1'b1;
    wait_neg(4);

    // Single rise on bit0
    gpio_switch = 4'h1;
    e = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge SYSTEMCLOCK);
      #1;
      if (e == 0 && switch_stable[0]) begin
        e = n;
        check("rise_strobe",    32'(switch_rise),    32'h1);
        check("rise_changed",   32'(switch_changed), 32'h1);
      end
    end
    check("rise_latency", 32'(e), 32'd18);
    check("rise_count",   32'(event_count), 32'd1);

    // Short glitch on bit1 is discarded
    @(negedge SYSTEMCLOCK);
    gpio_switch = 4'h3;
    wait_neg(10);
    gpio_switch = 4'h1;
    wait_neg(30);
    check("glitch_stable", 32'(switch_stable), 32'h1);
    check("glitch_count",  32'(event_count),   32'd1);

    // Bouncing bit2, then held high
    for (int t = 0; t < 8; t++) begin
      gpio_switch = (t % 2 == 0) ? 4'h5 : 4'h1;
      wait_neg(5);
    end
    gpio_switch = 4'h5;
    measure(2, 1'b1, e, p);
    check("bounce_latency", 32'(e), 32'd18);
    check("bounce_pulses",  32'(p), 32'd1);
    check("bounce_count",   32'(event_count), 32'd2);

    // Return to 4'h1 then step to 4'hE: simultaneous rise and fall
    @(negedge SYSTEMCLOCK);
    gpio_switch = 4'h1;
    wait_neg(25);
    check("pre_simul_stable", 32'(switch_stable), 32'h1);
    check("pre_simul_count",  32'(event_count),   32'd3);
    gpio_switch = 4'hE;
    p = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge SYSTEMCLOCK);
      #1;
      if (switch_changed) begin
        p++;
        check("simul_rise", 32'(switch_rise), 32'hE);
        check("simul_fall", 32'(switch_fall), 32'h1);
      end
    end
    check("simul_pulses", 32'(p), 32'd1);
    check("simul_count",  32'(event_count), 32'd4);

    // Asynchronous reset while cnt[0] is 10, then re-qualification
    @(negedge SYSTEMCLOCK);
    gpio_switch = 4'h1;
    repeat (12) @(posedge SYSTEMCLOCK);
    #2;
    RESET_N = 1'b0;
    #1;
    check("areset_stable",  32'(switch_stable),  32'h0);
    check("areset_rise",    32'(switch_rise),    32'h0);
    check("areset_fall",    32'(switch_fall),    32'h0);
    check("areset_changed", 32'(switch_changed), 32'h0);
    check("areset_count",   32'(event_count),    32'h0);
    wait_neg(3);
    RESET_N = 1'b1;
    measure(0, 1'b1, e, p);
    check("requal_latency", 32'(e), 32'd18);
    check("requal_count",   32'(event_count), 32'd1);

    // event_count wrap over 256 qualified toggles of bit3
    for (int k = 1; k <= 256; k++) begin
      gpio_switch = gpio_switch ^ 4'h8;
      wait_neg(20);
      if (k == 254) check("wrap_255", 32'(event_count), 32'd255);
      if (k == 255) check("wrap_0",   32'(event_count), 32'd0);
    end
    check("wrap_final", 32'(event_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_switch_debounce.md
# gpio_switch_debounce

Conditions the raw `gpio_switch` bank before it reaches the LED/control logic in `main`. Each asynchronous switch bit passes through a synchronizer and a per-bit debounce counter. The block outputs a clean, stable level plus single-cycle rise/fall strobes and a wrapping event counter. It sits directly upstream of `main`'s switch consumer and is clocked by the ~100 MHz system clock.

## Interface

Parameters:
- `WIDTH`, 4: number of switch bits.
- `SYNC_STAGES`, 2: flip-flop stages in each bit's synchronizer; legal range is ≥2.
- `DEBOUNCE_CYCLES`, 10000: consecutive cycles a synced bit must differ from its stable value before the stable value flips; legal range is ≥1.

Ports (clock and reset first):
- `SYSTEMCLOCK`  in  1  system clock; all state updates on the rising edge.
- `RESET_N`  in  1  reset, asynchronous assert, active-low.
- `gpio_switch`  in  WIDTH  raw switch levels, asynchronous to `SYSTEMCLOCK`.
- `switch_stable`  out  WIDTH  debounced level.
- `switch_rise`  out  WIDTH  one-cycle strobe per bit on a 0→1 transition of `switch_stable`.
- `switch_fall`  out  WIDTH  one-cycle strobe per bit on a 1→0 transition of `switch_stable`.
- `switch_changed`  out  1  one-cycle strobe; equals the OR of `switch_rise | switch_fall`.
- `event_count`  out  8  count of cycles in which `switch_changed` was high; wraps.

## Operation

- **Synchronizer:** each bit passes through a `SYNC_STAGES`-deep flop chain. The last stage is `sync[i]`.
- **Debounce counter:** each bit has its own counter, `cnt[i]`, of width clog2(`DEBOUNCE_CYCLES`+1).
  - If `sync[i]` == `switch_stable[i]`, `cnt[i]` is cleared to 0.
  - If they differ and `cnt[i]` < `DEBOUNCE_CYCLES`-1, `cnt[i]` increments.
  - If they differ and `cnt[i]` == `DEBOUNCE_CYCLES`-1, `switch_stable[i]` toggles and `cnt[i]` clears, both on the same edge.
- **Glitch rejection:** any excursion shorter than `DEBOUNCE_CYCLES` consecutive synced cycles is discarded. A single return to the stable level restarts the count from 0.
- **Strobes:** `switch_rise`, `switch_fall` and `switch_changed` are registered on the same edge that updates `switch_stable`. Each is high for exactly one cycle per transition.
- **Simultaneous transitions:** several bits may flip on the same edge, in either direction. Each bit raises its own rise or fall strobe. `switch_changed` pulses once, and `event_count` increments by exactly 1.
- **`event_count` width:** modulo-256; 255 + 1 → 0.
- **Reset:**
  - Asserting `RESET_N` low forces all synchronizer flops, counters and outputs to 0 immediately, without waiting for a clock edge.
  - Reset may arrive mid-count; partial counts are discarded.
  - After release, a switch held high is re-qualified from scratch. This produces a rise strobe and an `event_count` increment.

## Timing

- **Reset values:** `switch_stable` = 0, `switch_rise` = 0, `switch_fall` = 0, `switch_changed` = 0, `event_count` = 8'h00.
- **Latency:** a raw level change that stays steady reaches `switch_stable` on rising edge number `SYNC_STAGES` + `DEBOUNCE_CYCLES`. Edge 1 is the first edge that samples the new level.
- **`DEBOUNCE_CYCLES` = 1:** `switch_stable` lags `sync` by one edge.
- **Input assumptions:** no handshake; outputs are free-running. The consumer samples the strobes on the edge after they assert.
- **Outputs:** all outputs are driven directly from flops, with no combinational path from `gpio_switch`.

## Test plan

All scenarios use `WIDTH`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=16 and a 9.96 ns clock.

1. **Reset values:** hold `RESET_N`=0 with `gpio_switch`=4'hF for 5 cycles → all outputs 0 throughout; `event_count`=0.
2. **Single rise:** from reset release, step `gpio_switch` 4'h0→4'h1 and hold.
   - `switch_stable` becomes 4'h1 exactly 18 edges after the first sampling edge.
   - `switch_rise`=4'h1 and `switch_changed`=1 for one cycle.
   - `event_count`=1.
3. **Glitch and bounce rejection:**
   - Pulse bit1 high for 10 cycles → no output change.
   - Toggle bit2 every 5 cycles for 40 cycles, then hold high → exactly one `switch_rise`=4'h4, 18 edges after the final toggle.
4. **Simultaneous transitions:** with stable 4'h1, step input to 4'hE.
   - On the same cycle, `switch_rise`=4'hE and `switch_fall`=4'h1.
   - `switch_changed` pulses once; `event_count` increments by 1.
5. **Reset mid-count:** drive `RESET_N` low asynchronously while `cnt[0]`=10.
   - Outputs clear to 0 before the next edge.
   - After release with input held at 4'h1, the rise appears a full 18 edges later.
6. **`event_count` wrap:** generate 256 qualified toggles of bit3 → `event_count` reads 255 then 0; no strobe is lost.
